// File: rtl/vga_embarcacao_n.sv
// Vessel renderer for the 8x8 battleship board: draws up to N_CELULAS cells,
// colours hit cells, blinks a sunk vessel, and swaps in new data only at frame start.
module vga_embarcacao_n #(
  parameter int          N_CELULAS     = 4,
  parameter int          X0            = 16,
  parameter int          Y0            = 16,
  parameter int          PASSO_X       = 62,
  parameter int          PASSO_Y       = 57,
  parameter int          LARGURA       = 54,
  parameter int          ALTURA        = 49,
  parameter logic [2:0]  COR           = 3'b001,
  parameter logic [2:0]  COR_ATINGIDA  = 3'b100,
  parameter int          QUADROS_PISCA = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     areaAtiva,
  input  logic [9:0]               linha,
  input  logic [9:0]               coluna,
  input  logic [8*N_CELULAS-1:0]   posicoesEmbarcacao,
  input  logic [N_CELULAS-1:0]     atingidos,
  input  logic                     atualizar,
  output logic                     rgb_r,
  output logic                     rgb_g,
  output logic                     rgb_b,
  output logic                     afundado
);

  localparam int CW = (QUADROS_PISCA > 1) ? $clog2(QUADROS_PISCA) : 1;

  // Left/top border of a cell for a grid index 1..8; out-of-range indices wrap
  // harmlessly because such cells are disabled.
  function automatic logic [9:0] borda(input logic [3:0] p, input int base, input int passo);
    return 10'(base + (int'(p) - 1) * passo);
  endfunction

  function automatic logic valido(input logic [3:0] p);
    return (p >= 4'd1) && (p <= 4'd8);
  endfunction

  // Shadow (captured on atualizar) and active (committed at frame start) state
  logic [8*N_CELULAS-1:0] sh_pos_q, sh_pos_d;
  logic [N_CELULAS-1:0]   sh_hit_q, sh_hit_d;
  logic                   pendente_q, pendente_d;
  logic [9:0]             esq_q  [N_CELULAS];
  logic [9:0]             esq_d  [N_CELULAS];
  logic [9:0]             topo_q [N_CELULAS];
  logic [9:0]             topo_d [N_CELULAS];
  logic [N_CELULAS-1:0]   habil_q, habil_d;
  logic [N_CELULAS-1:0]   hit_q, hit_d;

  // Blink timing and sunk flag
  logic [CW-1:0]          quadro_q, quadro_d;
  logic                   fase_q, fase_d;
  logic                   afundado_q, afundado_d;

  // Pixel pipeline
  logic                   area_q, area_d;
  logic [N_CELULAS-1:0]   contem_q, contem_d;
  logic [2:0]             rgb_q, rgb_d;

  logic                   inicio;
  logic                   commit;
  logic                   ganha_hit;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    inicio     = (linha == 10'd0) && (coluna == 10'd0);
    commit     = inicio && pendente_q;

    sh_pos_d   = sh_pos_q;
    sh_hit_d   = sh_hit_q;
    pendente_d = pendente_q;
    esq_d      = esq_q;
    topo_d     = topo_q;
    habil_d    = habil_q;
    hit_d      = hit_q;
    quadro_d   = quadro_q;
    fase_d     = fase_q;

    // A strobe on a commit cycle lands in the shadow after the old data moves out
    if (atualizar) begin
      sh_pos_d   = posicoesEmbarcacao;
      sh_hit_d   = atingidos;
      pendente_d = 1'b1;
    end else if (commit) begin
      pendente_d = 1'b0;
    end

    if (commit) begin
      hit_d = sh_hit_q;
      for (int k = 0; k < N_CELULAS; k++) begin
        esq_d[k]   = borda(sh_pos_q[8*k +: 4], X0, PASSO_X);
        topo_d[k]  = borda(sh_pos_q[8*k+4 +: 4], Y0, PASSO_Y);
        habil_d[k] = valido(sh_pos_q[8*k +: 4]) && valido(sh_pos_q[8*k+4 +: 4]);
      end
    end

    if (inicio) begin
      if (quadro_q == CW'(QUADROS_PISCA - 1)) begin
        quadro_d = '0;
        fase_d   = ~fase_q;
      end else begin
        quadro_d = quadro_q + CW'(1);
      end
    end

    afundado_d = (|habil_q) && ((habil_q & ~hit_q) == '0);

    // Stage 1: containment uses the active borders. The frame-start pixel (0,0)
    // can never satisfy the strict left/top test, so no commit bypass is needed.
    area_d = areaAtiva;
    for (int k = 0; k < N_CELULAS; k++) begin
      contem_d[k] = habil_q[k]
                 && ({1'b0, linha}  > {1'b0, esq_q[k]})
                 && ({1'b0, linha}  < ({1'b0, esq_q[k]}  + 11'(LARGURA)))
                 && ({1'b0, coluna} > {1'b0, topo_q[k]})
                 && ({1'b0, coluna} < ({1'b0, topo_q[k]} + 11'(ALTURA)));
    end

    // Stage 2: lowest-index containing cell decides the colour
    ganha_hit = 1'b0;
    for (int k = N_CELULAS - 1; k >= 0; k--) begin
      if (contem_q[k]) ganha_hit = hit_q[k];
    end
    rgb_d = 3'b000;
    if (area_q && (|contem_q) && !(afundado_q && !fase_q)) begin
      rgb_d = ganha_hit ? COR_ATINGIDA : COR;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_pos_q   <= '0;
      sh_hit_q   <= '0;
      pendente_q <= 1'b0;
      // NOTE: the border arrays are reset like any other register because a
      // cleared board must be guaranteed blank straight out of reset.
      for (int k = 0; k < N_CELULAS; k++) begin
        esq_q[k]  <= '0;
        topo_q[k] <= '0;
      end
      habil_q    <= '0;
      hit_q      <= '0;
      quadro_q   <= '0;
      fase_q     <= 1'b1;
      afundado_q <= 1'b0;
      area_q     <= 1'b0;
      contem_q   <= '0;
      rgb_q      <= 3'b000;
    end else begin
      sh_pos_q   <= sh_pos_d;
      sh_hit_q   <= sh_hit_d;
      pendente_q <= pendente_d;
      esq_q      <= esq_d;
      topo_q     <= topo_d;
      habil_q    <= habil_d;
      hit_q      <= hit_d;
      quadro_q   <= quadro_d;
      fase_q     <= fase_d;
      afundado_q <= afundado_d;
      area_q     <= area_d;
      contem_q   <= contem_d;
      rgb_q      <= rgb_d;
    end
  end

  assign {rgb_r, rgb_g, rgb_b} = rgb_q;
  assign afundado              = afundado_q;

endmodule
